// File: rtl/grid_interact_arbiter.sv
// grid_interact_arbiter: owns the object grid, round-robin serializes player
// pick-up/place interactions onto it, and accepts level-setup cell loads.
// Ports:
//   clk_in, rst_n_in            clock, async active-low reset
//   req/grid_x/grid_y/...        per-player request and pose, sampled at grant
//   load_en/load_x/load_y/obj    single-cell level-setup write (IDLE only)
//   ack/result_obj/result_code   per-player completion pulse and outcome
//   busy                         high whenever not IDLE
//   object_grid                  registered grid contents [row][col]
module grid_interact_arbiter (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [1:0]              req,
  input  logic [1:0][3:0]         grid_x,
  input  logic [1:0][2:0]         grid_y,
  input  logic [1:0][1:0]         player_direction,
  input  logic [1:0][3:0]         held_obj,
  input  logic                    load_en,
  input  logic [3:0]              load_x,
  input  logic [2:0]              load_y,
  input  logic [3:0]              load_obj,
  output logic [1:0]              ack,
  output logic [1:0][3:0]         result_obj,
  output logic [1:0][1:0]         result_code,
  output logic                    busy,
  output logic [7:0][12:0][3:0]   object_grid
);

  localparam int unsigned X_W   = 4;
  localparam int unsigned Y_W   = 3;
  localparam int unsigned MAX_X = 12;
  localparam int unsigned MAX_Y = 7;

  localparam logic [3:0] EMPTY = 4'd0;
  localparam logic [3:0] WALL  = 4'd15;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;

  localparam logic [1:0] RC_PICKUP  = 2'd0;
  localparam logic [1:0] RC_PLACE   = 2'd1;
  localparam logic [1:0] RC_BLOCKED = 2'd2;
  localparam logic [1:0] RC_OOB     = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_ACK} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [1:0]              r_armed;
  logic                    r_last_grant;
  logic                    r_p;
  logic [3:0]              r_held;
  logic [X_W-1:0]          r_tx;
  logic [Y_W-1:0]          r_ty;
  logic                    r_inb;
  logic [1:0]              r_ack;
  logic [1:0][3:0]         r_res_obj;
  logic [1:0][1:0]         r_res_code;
  logic                    r_busy;
  logic [7:0][12:0][3:0]   r_grid;

  // Grant selection: on a tie the player not served last wins.
  logic [1:0]              w_elig;
  logic                    w_grant_p;
  logic                    w_grant;
  logic                    w_load_ok;

  assign w_elig    = req & r_armed;
  assign w_grant_p = (&w_elig) ? ~r_last_grant : w_elig[1];
  assign w_grant   = (r_state == ST_IDLE) && !load_en && (|w_elig);
  assign w_load_ok = load_en && (32'(load_x) <= MAX_X);

  // Target cell at one extra bit of width so edge moves land out of range
  // instead of wrapping onto a real cell.
  logic [X_W:0]            w_px, w_tx;
  logic [Y_W:0]            w_py, w_ty;
  logic                    w_inb;

  always_comb begin
    w_px = (X_W+1)'(grid_x[w_grant_p]);
    w_py = (Y_W+1)'(grid_y[w_grant_p]);
    w_tx = w_px;
    w_ty = w_py;
    case (player_direction[w_grant_p])
      DIR_LEFT:  w_tx = w_px - (X_W+1)'(1);
      DIR_RIGHT: w_tx = w_px + (X_W+1)'(1);
      DIR_UP:    w_ty = w_py - (Y_W+1)'(1);
      default:   w_ty = w_py + (Y_W+1)'(1);
    endcase
    w_inb = (32'(w_px) <= MAX_X) && (32'(w_tx) <= MAX_X) && (32'(w_ty) <= MAX_Y);
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic; a load in IDLE pre-empts any grant that cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read-modify-write decision for the registered interaction.
  logic [X_W-1:0]          w_rd_x;
  logic [Y_W-1:0]          w_rd_y;
  logic [3:0]              w_cell;
  logic [1:0]              w_code;
  logic [3:0]              w_res;
  logic                    w_we;
  logic [3:0]              w_wval;

  always_comb begin
    w_rd_x = r_inb ? r_tx : '0;
    w_rd_y = r_inb ? r_ty : '0;
    w_cell = r_grid[w_rd_y][w_rd_x];
    w_code = RC_BLOCKED;
    w_res  = r_held;
    w_we   = 1'b0;
    w_wval = EMPTY;
    if (!r_inb) begin
      w_code = RC_OOB;
    end else if (w_cell == WALL || r_held == WALL) begin
      w_code = RC_BLOCKED;
    end else if (r_held == EMPTY && w_cell != EMPTY) begin
      w_code = RC_PICKUP;
      w_res  = w_cell;
      w_we   = 1'b1;
      w_wval = EMPTY;
    end else if (r_held != EMPTY && w_cell == EMPTY) begin
      w_code = RC_PLACE;
      w_res  = EMPTY;
      w_we   = 1'b1;
      w_wval = r_held;
    end
  end

  // A low req re-arms its player even in the ACK cycle that disarms it.
  logic [1:0]              w_ack_clr;
  assign w_ack_clr = (r_state == ST_ACK) ? (2'b01 << r_p) : 2'b00;

  // Datapath, grid and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_armed      <= 2'b11;
      r_last_grant <= 1'b1;
      r_p          <= 1'b0;
      r_held       <= EMPTY;
      r_tx         <= '0;
      r_ty         <= '0;
      r_inb        <= 1'b0;
      r_ack        <= '0;
      r_res_obj    <= '0;
      r_res_code   <= '0;
      r_busy       <= 1'b0;
      r_grid       <= '0;
    end else begin
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ack   <= '0;
      r_armed <= (r_armed & ~w_ack_clr) | ~req;
      if (w_grant) begin
        r_p    <= w_grant_p;
        r_held <= held_obj[w_grant_p];
        r_tx   <= w_tx[X_W-1:0];
        r_ty   <= w_ty[Y_W-1:0];
        r_inb  <= w_inb;
      end
      if (r_state == ST_IDLE && w_load_ok) begin
        r_grid[load_y][load_x] <= load_obj;
      end
      if (r_state == ST_EXEC) begin
        if (w_we) r_grid[r_ty][r_tx] <= w_wval;
        r_ack[r_p]      <= 1'b1;
        r_res_obj[r_p]  <= w_res;
        r_res_code[r_p] <= w_code;
      end
      if (r_state == ST_ACK) begin
        r_last_grant <= r_p;
      end
    end
  end

  assign ack         = r_ack;
  assign result_obj  = r_res_obj;
  assign result_code = r_res_code;
  assign busy        = r_busy;
  assign object_grid = r_grid;

endmodule

// File: tb/tb_grid_interact_arbiter.sv
// Bench for grid_interact_arbiter: directed scenarios plus random traffic,
// checked against a cell-array reference model of the interaction rules.
module tb_grid_interact_arbiter;

  localparam int DL = 0, DR = 1, DU = 2, DD = 3;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in;
  logic [1:0]            req;
  logic [1:0][3:0]       grid_x;
  logic [1:0][2:0]       grid_y;
  logic [1:0][1:0]       player_direction;
  logic [1:0][3:0]       held_obj;
  logic                  load_en;
  logic [3:0]            load_x;
  logic [2:0]            load_y;
  logic [3:0]            load_obj;
  logic [1:0]            ack;
  logic [1:0][3:0]       result_obj;
  logic [1:0][1:0]       result_code;
  logic                  busy;
  logic [7:0][12:0][3:0] object_grid;

  grid_interact_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req(req), .grid_x(grid_x),
    .grid_y(grid_y), .player_direction(player_direction), .held_obj(held_obj),
    .load_en(load_en), .load_x(load_x), .load_y(load_y), .load_obj(load_obj),
    .ack(ack), .result_obj(result_obj), .result_code(result_code),
    .busy(busy), .object_grid(object_grid)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int m [8][13];
  int m_last;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0][12:0][3:0] exp_grid();
    logic [7:0][12:0][3:0] g;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 13; x++)
        g[y][x] = 4'(m[y][x]);
    return g;
  endfunction

  task automatic chk_grid(input string tag);
    logic [7:0][12:0][3:0] g;
    g = exp_grid();
    tests++;
    assert (object_grid === g) else begin
      fails++;
      $error("FAIL %s grid observed=%h expected=%h", tag, object_grid, g);
    end
  endtask

  function automatic void model_clear();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 13; x++)
        m[y][x] = 0;
  endfunction

  // Reference interaction: codes 0=PICKUP 1=PLACE 2=BLOCKED 3=OUT_OF_BOUNDS.
  function automatic void model_op(input int x, input int y, input int dir,
                                   input int held, output int code, output int obj);
    int tx, ty, c;
    tx = x; ty = y;
    case (dir)
      DL: tx = x - 1;
      DR: tx = x + 1;
      DU: ty = y - 1;
      default: ty = y + 1;
    endcase
    code = 2; obj = held;
    if (x > 12 || tx < 0 || tx > 12 || ty < 0 || ty > 7) begin
      code = 3;
    end else begin
      c = m[ty][tx];
      if (c == 15 || held == 15) code = 2;
      else if (held == 0 && c != 0) begin code = 0; obj = c; m[ty][tx] = 0; end
      else if (held != 0 && c == 0) begin code = 1; obj = 0; m[ty][tx] = held; end
    end
  endfunction

  task automatic set_player(input int p, input int x, input int y, input int dir, input int held);
    grid_x[p] = 4'(x);
    grid_y[p] = 3'(y);
    player_direction[p] = 2'(dir);
    held_obj[p] = 4'(held);
  endtask

  task automatic do_load(input int x, input int y, input int obj);
    load_en = 1'b1; load_x = 4'(x); load_y = 3'(y); load_obj = 4'(obj);
    tick();
    load_en = 1'b0;
    if (x <= 12) m[y][x] = obj;
    chk_grid("load");
  endtask

  task automatic do_one(input string tag, input int p, input int x, input int y,
                        input int dir, input int held);
    int ec, eo, n;
    set_player(p, x, y, dir, held);
    model_op(x, y, dir, held, ec, eo);
    m_last = p;
    req[p] = 1'b1;
    tick();
    set_player(p, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
    n = 1;
    while (!ack[p] && n < 8) begin tick(); n++; end
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_obj"}, result_obj[p], eo);
    chk({tag, "_code"}, result_code[p], ec);
    chk({tag, "_other_ack"}, ack[p^1], 0);
    req[p] = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, ack, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk_grid(tag);
  endtask

  task automatic run_pair(input string tag,
                          input int x0, input int y0, input int d0, input int h0,
                          input int x1, input int y1, input int d1, input int h1);
    int w, o;
    int ec[2], eo[2], ta[2];
    set_player(0, x0, y0, d0, h0);
    set_player(1, x1, y1, d1, h1);
    w = (m_last == 1) ? 0 : 1;
    o = 1 - w;
    if (w == 0) begin
      model_op(x0, y0, d0, h0, ec[0], eo[0]);
      model_op(x1, y1, d1, h1, ec[1], eo[1]);
    end else begin
      model_op(x1, y1, d1, h1, ec[1], eo[1]);
      model_op(x0, y0, d0, h0, ec[0], eo[0]);
    end
    m_last = o;
    ta[0] = 0; ta[1] = 0;
    req = 2'b11;
    for (int t = 1; t <= 10; t++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (ack[p] && ta[p] == 0) begin
          ta[p] = t;
          chk({tag, "_obj"}, result_obj[p], eo[p]);
          chk({tag, "_code"}, result_code[p], ec[p]);
        end
      end
    end
    chk({tag, "_first_latency"}, ta[w], 2);
    chk({tag, "_second_latency"}, ta[o], 5);
    req = 2'b00;
    tick();
    chk_grid(tag);
  endtask

  initial begin
    int ec, eo, cnt, n;
    rst_n_in = 1'b0;
    req = '0; grid_x = '0; grid_y = '0; player_direction = '0; held_obj = '0;
    load_en = 1'b0; load_x = '0; load_y = '0; load_obj = '0;
    model_clear();
    m_last = 1;
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_obj", result_obj, 0);
    chk("rst_res_code", result_code, 0);
    chk_grid("rst_grid");
    rst_n_in = 1'b1;
    tick();

    // Tie straight out of reset: player 0 first, player 1 three cycles later.
    run_pair("tie_reset", 2, 2, DR, 0, 5, 5, DL, 3);

    // Pickup, place, full-into-full.
    do_load(5, 3, 4);
    do_one("pickup", 0, 4, 3, DR, 0);
    do_one("place", 0, 8, 1, DD, 7);
    do_one("full_full", 1, 8, 3, DU, 2);

    // Edge moves and walls.
    do_load(0, 3, 5);
    do_load(12, 4, 6);
    do_one("oob_left", 0, 0, 3, DL, 0);
    do_one("oob_right", 1, 12, 4, DR, 6);
    do_one("oob_up", 0, 5, 0, DU, 0);
    do_one("oob_down", 1, 6, 7, DD, 3);
    do_one("oob_x13", 0, 13, 2, DL, 0);
    do_load(3, 2, 15);
    do_one("wall_cell", 1, 2, 2, DR, 0);
    do_one("wall_held", 0, 9, 5, DU, 15);
    do_load(13, 1, 9);

    // Same cell contended, then alternation across re-arms.
    do_load(6, 6, 4);
    run_pair("same_cell", 5, 6, DR, 0, 7, 6, DL, 0);
    run_pair("alt_a", 1, 1, DU, 0, 10, 1, DU, 0);
    run_pair("alt_b", 1, 5, DR, 0, 10, 5, DL, 0);

    // Held-high req is served once; a one-cycle drop re-arms it.
    set_player(0, 4, 4, DR, 8);
    model_op(4, 4, DR, 8, ec, eo);
    m_last = 0;
    req[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack[0]) begin
        cnt++;
        chk("rearm_first_code", result_code[0], ec);
      end
    end
    chk("rearm_one_ack", cnt, 1);
    req[0] = 1'b0;
    tick();
    model_op(4, 4, DR, 8, ec, eo);
    req[0] = 1'b1;
    n = 0;
    while (!ack[0] && n < 8) begin tick(); n++; end
    chk("rearm_second_latency", n, 2);
    chk("rearm_second_code", result_code[0], ec);
    chk("rearm_second_obj", result_obj[0], eo);
    req[0] = 1'b0;
    tick();
    chk_grid("rearm");

    // Load while busy is dropped; req dropped mid-op still completes.
    set_player(1, 11, 0, DD, 0);
    model_op(11, 0, DD, 0, ec, eo);
    m_last = 1;
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    load_en = 1'b1; load_x = 4'd2; load_y = 3'd7; load_obj = 4'd9;
    tick();
    load_en = 1'b0;
    chk("busy_load_ack", ack[1], 1);
    chk("busy_load_code", result_code[1], ec);
    tick();
    chk_grid("busy_load");

    // Reset during EXEC: no ack, grid cleared, then normal service.
    set_player(0, 3, 6, DR, 9);
    req[0] = 1'b1;
    tick();
    rst_n_in = 1'b0;
    #1;
    model_clear();
    m_last = 1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk_grid("midrst_grid");
    req = '0;
    tick();
    chk("midrst_ack_later", ack, 0);
    rst_n_in = 1'b1;
    tick();
    do_one("post_rst", 0, 3, 6, DR, 9);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 15));
      end else begin
        do_one("rand", $urandom_range(0, 1), $urandom_range(0, 13), $urandom_range(0, 7),
               $urandom_range(0, 3), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_interact_arbiter.md
# grid_interact_arbiter

Owns the kitchen object grid and serializes pick-up/place interactions from two players onto it. Each player requests an interaction with the cell directly in front of it. The block arbitrates round-robin, performs one read-modify-write per grant, and returns the object the player now holds plus a status code. It drives the object_grid bus consumed by the renderer and the in-front lookup logic. A load port writes individual cells for level setup.

## Interface
- EMPTY, 4'd0: object code meaning "no object".
- WALL, 4'd15: object code that can never be picked up or overwritten by players.
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- req  input  [1:0]  per-player interaction request, held high until ack.
- grid_x  input  [1:0][3:0]  player column, 0..12.
- grid_y  input  [1:0][2:0]  player row, 0..7.
- player_direction  input  [1:0][1:0]  facing direction: LEFT=0, RIGHT=1, UP=2, DOWN=3.
- held_obj  input  [1:0][3:0]  object the player currently holds.
- load_en  input  1  level-setup cell write strobe.
- load_x  input  4  load target column.
- load_y  input  3  load target row.
- load_obj  input  4  object code to load.
- ack  output  [1:0]  one-cycle completion pulse per player.
- result_obj  output  [1:0][3:0]  object the player holds after the interaction; valid while ack is high.
- result_code  output  [1:0][1:0]  outcome: 0=PICKUP, 1=PLACE, 2=BLOCKED, 3=OUT_OF_BOUNDS.
- busy  output  1  high whenever the state is not IDLE.
- object_grid  output  [7:0][12:0][3:0]  registered grid contents.

## Operation
- States: IDLE, EXEC, ACK.
- IDLE transitions:
  - If load_en is high: write load_obj to cell (load_y, load_x) and stay in IDLE. Load has priority over grants that cycle.
  - Load with load_x > 12: ignored.
  - Otherwise, if any player is eligible, grant one and go to EXEC.
- Eligible means req[p] is high and armed[p] is set.
- Both players eligible: grant the player not served last. last_grant resets to 1, so player 0 wins the first tie.
- On grant, register:
  - player index p;
  - held_obj[p];
  - the target cell: LEFT (y, x-1), RIGHT (y, x+1), UP (y-1, x), DOWN (y+1, x);
  - inbounds flag: false if LEFT with x=0, RIGHT with x≥12, UP with y=0, DOWN with y=7, or input x>12.
- Target arithmetic is done at 5-bit column / 4-bit row width, so out-of-bounds targets never wrap onto a real cell.
- EXEC: read the target cell c and decide (first match wins):
  - !inbounds: code OUT_OF_BOUNDS, result=held, no write.
  - c==WALL or held==WALL: BLOCKED, result=held, no write.
  - held==EMPTY and c!=EMPTY: PICKUP, cell←EMPTY, result=c.
  - held!=EMPTY and c==EMPTY: PLACE, cell←held, result=EMPTY.
  - Otherwise (both empty or both full): BLOCKED, result=held, no write.
- EXEC always goes to ACK.
- ACK:
  - ack[p]=1 for exactly one cycle; result_obj[p] and result_code[p] are valid.
  - Clear armed[p]; set last_grant=p.
  - Go to IDLE.
- armed[p] is set in any cycle where req[p] is low. A requester must therefore drop req for at least one cycle before it can be served again; a held-high req is never served twice.
- result_obj and result_code hold their last values between acks.
- Player inputs are sampled only in the grant cycle. Changes afterwards have no effect on the interaction in progress.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, all grid cells=EMPTY;
  - ack=0, busy=0, result_obj=0, result_code=0;
  - last_grant=1, armed=2'b11.
- Grant in IDLE cycle N: EXEC in N+1, grid write at the N+1→N+2 edge, ack high in N+2, IDLE in N+3.
- The earliest next grant is decided in N+3, so throughput is one interaction per 3 cycles.
- object_grid reflects a player write from cycle N+2, and a load write from the cycle after load_en.
- Two players targeting the same cell are served in sequence; the second sees the first's update.
- load_en while busy: ignored, with no queueing.
- Reset mid-operation: abort immediately, no ack, grid cleared.
- A req dropped while busy: the granted interaction still completes and acks.

## Test plan
- Pickup: load cell (3,5)=4. Player 0 at x=4, y=3, RIGHT, held=0, req → ack[0] two cycles after grant, result_obj=4, code PICKUP, cell (3,5)=0.
- Place into empty, and full into full: held=7 facing empty cell → PLACE, cell=7, result=0. Then held=2 facing that cell → BLOCKED, result=2, cell stays 7.
- Bounds and WALL:
  - x=0 LEFT, x=12 RIGHT, y=0 UP, y=7 DOWN → OUT_OF_BOUNDS, no grid change anywhere (check (y,12), (y,0), (7,x), (0,x) unchanged).
  - Facing WALL → BLOCKED.
- Tie and fairness:
  - Both players request in the same cycle at reset → player 0 acked first, player 1 three cycles later.
  - Both hold req and re-arm → order alternates.
  - Both target the same cell holding 4 with empty hands → first gets PICKUP 4, second gets BLOCKED 0.
- Re-arm: hold req[0] high for 20 cycles → exactly one ack. Drop req[0] one cycle, raise again → second ack.
- Reset mid-op: assert rst_n_in low during EXEC → no ack, grid all EMPTY, busy=0. The next request is served normally.
